// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end types and constants: address/instruction widths,
// PC increment, the fetch-queue entry, and a saturating counter helper.
package legv8_pkg;

  localparam int ADDR_W = 64;
  localparam int INSN_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP  = 64'd4;
  localparam logic [INSN_W-1:0] NOP_INSN = 32'h0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] instr;
  } fetch_entry_t;

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake, hazard/redirect inputs and
// IF/ID outputs. master = fetch stage, slave = memory/pipeline side.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 64,
  parameter int INSN_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [INSN_W-1:0] imem_rdata;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              ifid_valid;
  logic [ADDR_W-1:0] ifid_pc;
  logic [INSN_W-1:0] ifid_instr;

  modport master (
    output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr,
    input  imem_ready, imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr,
    output imem_ready, imem_rdata, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// Small power-of-two FIFO of fetch entries with synchronous flush.
// Flush wins over push and pop on the same edge.
module fetch_queue
  import legv8_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  fetch_entry_t  mem_q [DEPTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full queue is legal when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, imem request logic and a fetch
// queue whose head feeds IF/ID. Define IF_FETCH_PERF_EN for perf counters.
module if_fetch_stage
  import legv8_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  if_fetch_stage_if.master  bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
  output logic [31:0]       perf_stall_cycles
`endif
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_entry_t      last_q, last_d;
  fetch_entry_t      head, shown, push_data;
  logic [CW-1:0]     q_count;
  logic              q_full, q_empty;
  logic              pop, req, fire;

  assign pop  = !q_empty && !bus.stall;
  assign req  = !RESET && !bus.branch_taken && (!q_full || pop);
  assign fire = req && bus.imem_ready;

  always_comb begin
    push_data       = '0;
    push_data.pc    = pc_q;
    push_data.instr = bus.imem_rdata;
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (CLOCK),
    .rst       (RESET),
    .push      (fire),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.branch_taken),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // IF/ID keeps showing the last head once the queue runs dry.
  always_comb begin
    pc_d = pc_q;
    if (bus.branch_taken)
      pc_d = {bus.branch_target[ADDR_W-1:2], 2'b00};
    else if (fire)
      pc_d = pc_q + ADDR_W'(PC_STEP);
    shown  = q_empty ? last_q : head;
    last_d = shown;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_q         <= RESET_PC;
      last_q.pc    <= '0;
      last_q.instr <= NOP_INSN;
    end else begin
      pc_q   <= pc_d;
      last_q <= last_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.ifid_valid = !q_empty;
  assign bus.ifid_pc    = shown.pc;
  assign bus.ifid_instr = shown.instr;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [31:0] perf_stall_q,   perf_stall_d;

  // A flush discards whatever the queue holds; fire is already blocked by it.
  always_comb begin
    perf_fetched_d = sat_add32(perf_fetched_q, 32'(fire));
    perf_flushed_d = perf_flushed_q;
    if (bus.branch_taken) perf_flushed_d = sat_add32(perf_flushed_q, 32'(q_count));
    perf_stall_d   = sat_add32(perf_stall_q, 32'(bus.stall && !q_empty));
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_flushed      = perf_flushed_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  logic unused_count;
  assign unused_count = ^q_count;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic, checked
// against a queue-based model of the fetch rules.
module tb_if_fetch_stage;
  localparam int          QD  = 2;
  localparam logic [63:0] RPC = 64'h0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic CLOCK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   failures = 0;

  ent_t        m_q[$];
  ent_t        m_last;
  logic [63:0] m_pc;

  always #5 CLOCK = ~CLOCK;

  if_fetch_stage_if #(.ADDR_W(64), .INSN_W(32)) bus ();
  assign bus.imem_rdata = bus.imem_addr[31:0] ^ 32'hA5A5_0000;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall_cycles;
`endif

  if_fetch_stage #(.ADDR_W(64), .INSN_W(32), .RESET_PC(RPC), .QDEPTH(QD)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetched (perf_fetched), .perf_flushed (perf_flushed),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  task automatic model_reset();
    m_q.delete();
    m_pc   = RPC;
    m_last = '{64'h0, 32'h0};
  endtask

  // Applies one clock edge of the fetch rules to the model.
  task automatic model_step();
    bit pop, fire;
    if (RESET) begin model_reset(); return; end
    if (m_q.size() != 0) m_last = m_q[0];
    if (bus.branch_taken) begin
      m_q.delete();
      m_pc = {bus.branch_target[63:2], 2'b00};
      return;
    end
    pop  = (m_q.size() != 0) && !bus.stall;
    fire = ((m_q.size() < QD) || pop) && bus.imem_ready;
    if (pop) void'(m_q.pop_front());
    if (fire) begin
      m_q.push_back('{m_pc, m_pc[31:0] ^ 32'hA5A5_0000});
      m_pc = m_pc + 64'd4;
    end
  endtask

  // {ifid_valid, ifid_pc, ifid_instr, imem_req, imem_addr}
  function automatic logic [161:0] expv();
    ent_t h;
    logic ev, er;
    ev = (m_q.size() != 0);
    h  = m_last;
    if (ev) h = m_q[0];
    er = !RESET && !bus.branch_taken && ((m_q.size() < QD) || (ev && !bus.stall));
    return {ev, h.pc, h.ins, er, m_pc};
  endfunction

  task automatic drive(input bit rst, input bit rdy, input bit st, input bit br,
                       input logic [63:0] tgt);
    RESET = rst;
    bus.imem_ready = rdy;
    bus.stall = st;
    bus.branch_taken = br;
    bus.branch_target = tgt;
    if (rst) model_reset();
    @(negedge CLOCK);
  endtask

  task automatic advance();
    @(posedge CLOCK);
    model_step();
    #1;
  endtask

  function automatic logic [161:0] actv();
    return {bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.imem_req, bus.imem_addr};
  endfunction

  task automatic test_reset();
    logic [161:0] act, exp;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 64'h0);
      act = actv(); exp = expv(); checks++;
      if (act !== exp || act !== 162'h0) begin
        failures++; $display("FAIL reset cyc%0d act=%h exp=%h", i, act, exp);
      end
      advance();
    end
  endtask

  task automatic test_stream();
    logic [161:0] act, exp;
    drive(1, 1, 0, 0, 64'h0); advance();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 64'h0);
      act = actv(); exp = expv(); checks++;
      if (act !== exp) begin
        failures++; $display("FAIL stream cyc%0d act=%h exp=%h", i, act, exp);
      end
      if (i >= 1) begin
        checks++;
        if (!bus.ifid_valid || bus.ifid_pc !== 64'(4 * (i - 1))) begin
          failures++;
          $display("FAIL stream_seq cyc%0d valid=%b pc=%h want pc=%h", i,
                   bus.ifid_valid, bus.ifid_pc, 64'(4 * (i - 1)));
        end
      end
      advance();
    end
  endtask

  task automatic test_ready_wait();
    logic [161:0] act, exp;
    int n8 = 0;
    drive(1, 1, 0, 0, 64'h0); advance();
    for (int i = 0; i < 10; i++) begin
      drive(0, !(i >= 2 && i <= 4), 0, 0, 64'h0);
      act = actv(); exp = expv(); checks++;
      if (act !== exp) begin
        failures++; $display("FAIL ready_wait cyc%0d act=%h exp=%h", i, act, exp);
      end
      if (i >= 2 && i <= 4) begin
        checks++;
        if (bus.imem_addr !== 64'h8) begin
          failures++; $display("FAIL wait_addr cyc%0d addr=%h want=8", i, bus.imem_addr);
        end
      end
      if (bus.ifid_valid && bus.ifid_pc == 64'h8) n8++;
      advance();
    end
    checks++;
    if (n8 != 1) begin
      failures++; $display("FAIL wait_once seen=%0d want=1", n8);
    end
  endtask

  task automatic test_stall();
    logic [161:0] act, exp;
    logic [63:0] want[3] = '{64'h4, 64'h8, 64'hC};
    drive(1, 1, 0, 0, 64'h0); advance();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, (i >= 2 && i <= 5), 0, 64'h0);
      act = actv(); exp = expv(); checks++;
      if (act !== exp) begin
        failures++; $display("FAIL stall cyc%0d act=%h exp=%h", i, act, exp);
      end
      if (i >= 2 && i <= 5) begin
        checks++;
        if (bus.ifid_pc !== 64'h4 || !bus.ifid_valid || (i == 5 && bus.imem_req !== 1'b0)) begin
          failures++;
          $display("FAIL stall_hold cyc%0d pc=%h valid=%b req=%b want pc=4", i,
                   bus.ifid_pc, bus.ifid_valid, bus.imem_req);
        end
      end
      if (i >= 6) begin
        checks++;
        if (bus.ifid_pc !== want[i-6] || !bus.ifid_valid) begin
          failures++; $display("FAIL stall_order cyc%0d pc=%h want=%h", i, bus.ifid_pc, want[i-6]);
        end
      end
      advance();
    end
  endtask

  task automatic test_branch_stall();
    logic [161:0] act, exp;
    drive(1, 1, 0, 0, 64'h0); advance();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, (i == 2), (i == 2), 64'h103);
      act = actv(); exp = expv(); checks++;
      if (act !== exp) begin
        failures++; $display("FAIL branch cyc%0d act=%h exp=%h", i, act, exp);
      end
      if (i == 3) begin
        checks++;
        if (bus.ifid_valid !== 1'b0 || bus.imem_addr !== 64'h100) begin
          failures++; $display("FAIL branch_redirect valid=%b addr=%h want 0/100",
                               bus.ifid_valid, bus.imem_addr);
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 64'h100) begin
          failures++; $display("FAIL branch_target valid=%b pc=%h want 1/100",
                               bus.ifid_valid, bus.ifid_pc);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [161:0] act, exp;
    logic [63:0] first = '1;
    bit bad = 0;
    drive(1, 1, 0, 0, 64'h0); advance();
    for (int i = 0; i < 10; i++) begin
      drive(0, (i == 4) ? 1'b1 : 1'($urandom), 0, (i == 2 || i == 3),
            (i == 2) ? 64'h200 : 64'h300);
      act = actv(); exp = expv(); checks++;
      if (act !== exp) begin
        failures++; $display("FAIL b2b cyc%0d act=%h exp=%h", i, act, exp);
      end
      if (i > 3 && bus.ifid_valid) begin
        if (first == '1) first = bus.ifid_pc;
        if (bus.ifid_pc >= 64'h200 && bus.ifid_pc < 64'h300) bad = 1;
      end
      advance();
    end
    checks++;
    if (first !== 64'h300 || bad) begin
      failures++; $display("FAIL b2b_first first=%h stale=%0d want 300/0", first, bad);
    end
  endtask

  task automatic test_wrap_reset();
    logic [161:0] act, exp;
    drive(1, 1, 0, 0, 64'h0); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, (i != 2), 0, (i == 0), 64'hFFFF_FFFF_FFFF_FFFE);
      act = actv(); exp = expv(); checks++;
      if (act !== exp) begin
        failures++; $display("FAIL wrap cyc%0d act=%h exp=%h", i, act, exp);
      end
      if (i == 2) begin
        checks++;
        if (bus.imem_addr !== 64'h0 || bus.ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
          failures++; $display("FAIL wrap_addr addr=%h pc=%h want 0/FFFFFFFFFFFFFFFC",
                               bus.imem_addr, bus.ifid_pc);
        end
      end
      if (i < 2) advance();
    end
    #1 RESET = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.ifid_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== RPC) begin
      failures++; $display("FAIL async_reset valid=%b req=%b addr=%h want 0/0/%h",
                           bus.ifid_valid, bus.imem_req, bus.imem_addr, RPC);
    end
    @(posedge CLOCK); #1;
  endtask

  task automatic test_random();
    logic [161:0] act, exp;
    drive(1, 1, 0, 0, 64'h0); advance();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
            {$urandom, $urandom});
      act = actv(); exp = expv(); checks++;
      if (act !== exp) begin
        failures++; $display("FAIL random cyc%0d act=%h exp=%h", i, act, exp);
      end
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_ready_wait();
    test_stall();
    test_branch_stall();
    test_back_to_back();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
